// File: rtl/pkt_egress_ctrl_if.sv
// Egress bundle: FIFO read port on one side, downstream word interface on the other.
// The controller takes the master modport; the FIFO/sink environment takes the slave one.
interface pkt_egress_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
);
    logic                             fifo_empty;
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout;
    logic                             fifo_reb;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_reb,
        output out_data,
        output out_ctrl,
        output out_wr,
        input  out_rdy
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_reb,
        input  out_data,
        input  out_ctrl,
        input  out_wr,
        output out_rdy
    );
endinterface

// File: rtl/pkt_egress_ctrl.sv
// Packet egress controller: drains FIFO words through a 2-entry skid buffer,
// tracks packet framing, gates new packets on pc_en and keeps statistics.
module pkt_egress_ctrl #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    CTRL_WIDTH = 8,
    parameter logic [CTRL_WIDTH-1:0] HDR_CTRL   = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pc_en,
    input  logic                  clr_stats,
    output logic [31:0]           pkt_count,
    output logic [31:0]           word_count,
    output logic [31:0]           err_count,
    pkt_egress_ctrl_if.master     eg
);

    localparam int W = DATA_WIDTH + CTRL_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        BODY,
        EOP_WORD
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [W-1:0]          ent0_q;
    logic [W-1:0]          ent1_q;
    logic [1:0]            cnt_q;
    logic                  inflight_q;

    logic                  push;
    logic                  pop;
    logic                  reb;
    logic                  at_boundary;
    logic                  read_allowed;
    logic [2:0]            fill;
    logic [CTRL_WIDTH-1:0] push_ctrl;
    logic                  is_hdr;
    logic                  is_zero;
    logic                  pkt_inc;
    logic                  err_inc;

    assign push      = inflight_q;
    assign pop       = (cnt_q != 2'd0) & eg.out_rdy;
    assign push_ctrl = eg.fifo_dout[W-1:DATA_WIDTH];
    assign is_hdr    = (push_ctrl == HDR_CTRL);
    assign is_zero   = (push_ctrl == '0);

    // EOP_WORD is a one-cycle packet-end marker, so it counts as a boundary.
    assign at_boundary  = (state_q == IDLE) | (state_q == EOP_WORD);
    assign read_allowed = !(pc_en & at_boundary & !inflight_q);

    // Room is judged after this cycle's pop so a full-rate stream never stalls.
    assign fill = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
    assign reb  = reset_n & !eg.fifo_empty & (fill < 3'd2) & read_allowed;

    assign eg.fifo_reb = reb;
    assign eg.out_wr   = pop;
    assign eg.out_data = (cnt_q != 2'd0) ? ent0_q[DATA_WIDTH-1:0] : '0;
    assign eg.out_ctrl = (cnt_q != 2'd0) ? ent0_q[W-1:DATA_WIDTH] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent0_q     <= '0;
            ent1_q     <= '0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= reb;
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_q <= eg.fifo_dout;
                    else               ent1_q <= eg.fifo_dout;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    ent1_q <= '0;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_q <= eg.fifo_dout;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= eg.fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pkt_inc = 1'b0;
        err_inc = 1'b0;
        if (push) begin
            unique case (state_q)
                IDLE, EOP_WORD: begin
                    unique case (1'b1)
                        is_hdr:  state_d = HDR;
                        is_zero: begin
                            err_inc = 1'b1;
                            state_d = BODY;
                        end
                        default: begin
                            err_inc = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end
                HDR: begin
                    unique case (1'b1)
                        is_hdr:  state_d = HDR;
                        is_zero: state_d = BODY;
                        default: begin
                            pkt_inc = 1'b1;
                            state_d = EOP_WORD;
                        end
                    endcase
                end
                BODY: begin
                    if (!is_zero) begin
                        pkt_inc = 1'b1;
                        err_inc = is_hdr;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == EOP_WORD) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count  <= '0;
            word_count <= '0;
            err_count  <= '0;
        end else if (clr_stats) begin
            pkt_count  <= '0;
            word_count <= '0;
            err_count  <= '0;
        end else begin
            if (pkt_inc) pkt_count  <= pkt_count + 32'd1;
            if (pop)     word_count <= word_count + 32'd1;
            if (err_inc) err_count  <= err_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pkt_egress_ctrl.sv
// Directed bench for pkt_egress_ctrl: behavioural FIFO source, capturing sink,
// buffer-room tracker and a linear sequence of framing/flow-control scenarios.
module tb_pkt_egress_ctrl;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b1;
    logic        pc_en     = 1'b0;
    logic        clr_stats = 1'b0;
    logic [31:0] pkt_count;
    logic [31:0] word_count;
    logic [31:0] err_count;

    pkt_egress_ctrl_if bus ();

    pkt_egress_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pc_en      (pc_en),
        .clr_stats  (clr_stats),
        .pkt_count  (pkt_count),
        .word_count (word_count),
        .err_count  (err_count),
        .eg         (bus)
    );

    always #5 clk = ~clk;

    logic [71:0] fq[$];
    logic [71:0] rx[$];
    int          rx_cyc[$];
    int          cyc      = 0;
    int          checks   = 0;
    int          errors   = 0;
    int          occ_m    = 0;
    int          infl_m   = 0;
    int          reb_seen = 0;

    task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic fpush(logic [71:0] w);
        fq.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic push_pkt(logic [63:0] base);
        fpush({8'hFF, base});
        fpush({8'h00, base + 64'd1});
        fpush({8'h00, base + 64'd2});
        fpush({8'h00, base + 64'd3});
        fpush({8'h08, base + 64'd4});
    endtask

    task automatic check_pkt(int at, logic [63:0] base, string tag);
        logic [7:0] c;
        for (int i = 0; i < 5; i++) begin
            c = (i == 0) ? 8'hFF : (i == 4) ? 8'h08 : 8'h00;
            chk(tag, rx[at+i], {c, base + 64'(i)});
        end
    endtask

    task automatic wait_rx(int n, string tag);
        int k;
        k = 0;
        while (rx.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 72'(rx.size()), 72'(n));
    endtask

    // Read data appears one cycle after the strobe, like the SRAM FIFO.
    always @(posedge clk) begin
        if (bus.fifo_reb) begin
            bus.fifo_dout <= fq.pop_front();
            if (fq.size() == 0) bus.fifo_empty <= 1'b1;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_m  = 0;
            infl_m = 0;
        end else begin
            cyc++;
            if (bus.out_wr) begin
                rx.push_back({bus.out_ctrl, bus.out_data});
                rx_cyc.push_back(cyc);
            end
            if (bus.fifo_reb) begin
                reb_seen++;
                chk("reb_room",
                    72'((occ_m - int'(bus.out_wr) + infl_m) < 2), 72'd1);
            end
            occ_m  = occ_m + infl_m - int'(bus.out_wr);
            infl_m = int'(bus.fifo_reb);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        bus.out_rdy    = 1'b0;

        // T1: reset state, then one packet at full rate
        push_pkt(64'h1000);
        bus.out_rdy = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_out_wr", 72'(bus.out_wr), 72'd0);
        chk("rst_out_data", 72'(bus.out_data), 72'd0);
        chk("rst_out_ctrl", 72'(bus.out_ctrl), 72'd0);
        chk("rst_fifo_reb", 72'(bus.fifo_reb), 72'd0);
        chk("rst_pkt", 72'(pkt_count), 72'd0);
        chk("rst_word", 72'(word_count), 72'd0);
        chk("rst_err", 72'(err_count), 72'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_rx(5, "t1_rx_cnt");
        chk("t1_b2b", 72'(rx_cyc[4] - rx_cyc[0]), 72'd4);
        check_pkt(0, 64'h1000, "t1_data");
        repeat (3) @(negedge clk);
        chk("t1_pkt", 72'(pkt_count), 72'd1);
        chk("t1_word", 72'(word_count), 72'd5);
        chk("t1_err", 72'(err_count), 72'd0);

        // T2: sink toggles ready every cycle
        rx.delete();
        rx_cyc.delete();
        push_pkt(64'h2000);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.out_rdy = ~bus.out_rdy;
        end
        bus.out_rdy = 1'b1;
        chk("t2_rx_cnt", 72'(rx.size()), 72'd5);
        check_pkt(0, 64'h2000, "t2_data");
        chk("t2_pkt", 72'(pkt_count), 72'd2);
        chk("t2_word", 72'(word_count), 72'd10);

        // T3: pc_en in IDLE blocks the next packet
        rx.delete();
        @(negedge clk);
        pc_en = 1'b1;
        push_pkt(64'h3000);
        reb_seen = 0;
        repeat (20) @(negedge clk);
        chk("t3_reb_blocked", 72'(reb_seen), 72'd0);
        chk("t3_no_out", 72'(rx.size()), 72'd0);
        pc_en = 1'b0;
        #1;
        chk("t3_reb_resume", 72'(bus.fifo_reb), 72'd1);
        wait_rx(5, "t3_rx_cnt");
        check_pkt(0, 64'h3000, "t3_data");

        // T4: pc_en mid-packet lets the packet finish, then stops reads
        rx.delete();
        push_pkt(64'h4000);
        wait_rx(1, "t4_hdr_out");
        pc_en = 1'b1;
        wait_rx(5, "t4_rx_cnt");
        check_pkt(0, 64'h4000, "t4_data");
        repeat (3) @(negedge clk);
        rx.delete();
        reb_seen = 0;
        push_pkt(64'h5000);
        repeat (10) @(negedge clk);
        chk("t4_reb_stop", 72'(reb_seen), 72'd0);
        chk("t4_no_out", 72'(rx.size()), 72'd0);
        chk("t4_pkt", 72'(pkt_count), 72'd4);
        chk("t4_word", 72'(word_count), 72'd20);

        // T5: body word with no header after reset
        @(negedge clk);
        reset_n = 1'b0;
        fq.delete();
        bus.fifo_empty = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        pc_en   = 1'b0;
        rx.delete();
        fpush({8'h00, 64'hAAAA_5555});
        wait_rx(1, "t5_rx_cnt");
        repeat (2) @(negedge clk);
        chk("t5_data", rx[0], {8'h00, 64'hAAAA_5555});
        chk("t5_err", 72'(err_count), 72'd1);
        chk("t5_word", 72'(word_count), 72'd1);
        chk("t5_pkt", 72'(pkt_count), 72'd0);

        // T6: reset mid-packet, then clr_stats after two packets
        bus.out_rdy = 1'b0;
        rx.delete();
        fpush({8'hFF, 64'h6000});
        fpush({8'h00, 64'h6001});
        fpush({8'h00, 64'h6002});
        fpush({8'h00, 64'h6003});
        repeat (5) @(negedge clk);
        chk("t6_hold_wr", 72'(bus.out_wr), 72'd0);
        chk("t6_hold_data", 72'(bus.out_data), 72'h6000);
        bus.out_rdy = 1'b1;
        reset_n     = 1'b0;
        #1;
        chk("t6_rst_wr", 72'(bus.out_wr), 72'd0);
        chk("t6_rst_data", 72'(bus.out_data), 72'd0);
        chk("t6_rst_err", 72'(err_count), 72'd0);
        chk("t6_rst_word", 72'(word_count), 72'd0);
        fq.delete();
        bus.fifo_empty = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        rx.delete();
        push_pkt(64'h7000);
        push_pkt(64'h8000);
        wait_rx(10, "t6_rx_cnt");
        repeat (3) @(negedge clk);
        check_pkt(0, 64'h7000, "t6_pkt_a");
        check_pkt(5, 64'h8000, "t6_pkt_b");
        chk("t6_pkt", 72'(pkt_count), 72'd2);
        chk("t6_word", 72'(word_count), 72'd10);
        chk("t6_err", 72'(err_count), 72'd0);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        chk("t6_clr_pkt", 72'(pkt_count), 72'd0);
        chk("t6_clr_word", 72'(word_count), 72'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
